// File: rtl/cache_mem_responder_if.sv
// Request/response bundle between the data cache memory port and its responder.
// Latency: none, wires only.
// Backpressure: rd_ready/wr_ready gate acceptance; read beats have no backpressure.
interface cache_mem_responder_if;
  logic         rd_req;
  logic [63:0]  rd_addr;
  logic [2:0]   rd_type;
  logic         rd_ready;
  logic [63:0]  rdata;
  logic         rlast;
  logic         rvalid;

  logic         wr_req;
  logic [63:0]  wr_addr;
  logic [127:0] wdata;
  logic [2:0]   wr_type;
  logic [7:0]   wstrb;
  logic         wr_ready;

  // Cache side: issues requests and consumes read beats.
  modport master (
    output rd_req, rd_addr, rd_type,
    input  rd_ready, rdata, rlast, rvalid,
    output wr_req, wr_addr, wdata, wr_type, wstrb,
    input  wr_ready
  );

  // Memory side: accepts requests and produces read beats.
  modport slave (
    input  rd_req, rd_addr, rd_type,
    output rd_ready, rdata, rlast, rvalid,
    input  wr_req, wr_addr, wdata, wr_type, wstrb,
    output wr_ready
  );
endinterface

// File: rtl/cache_mem_responder.sv
// RAM-backed responder closing the data cache miss path (single beats, 2-beat line refills, stores, write-backs).
// Latency: first read beat RD_LAT cycles after accept; writes commit at accept, then WR_LAT busy cycles.
// Backpressure: one transaction outstanding; ready drops outside IDLE, a concurrent write beats a read.
module cache_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          MEM_WORDS = 4096,
  parameter int          RD_LAT    = 2,
  parameter int          WR_LAT    = 1
) (
  input logic                  clk,
  input logic                  rst,
  cache_mem_responder_if.slave bus
);

  localparam int IW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BEAT, WR_BUSY} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          rd_line, rd_line_nxt;
  logic [IW-1:0] rd_idx, rd_idx_nxt;

  // Beat to be registered onto the read channel at the coming edge.
  logic          emit;
  logic          emit_last;
  logic [IW-1:0] emit_idx;

  logic          rd_acc;
  logic          wr_acc;
  logic [IW-1:0] wr_word_idx;
  logic [IW-1:0] wr_line_idx;
  logic [IW-1:0] rd_word_idx;
  logic [IW-1:0] rd_line_idx;

  logic [63:0]   mem [MEM_WORDS];

  // Out-of-window addresses wrap onto the store rather than faulting.
  function automatic logic [IW-1:0] word_idx(input logic [63:0] addr);
    return IW'((addr - 64'(BASE_ADDR)) >> 3);
  endfunction

  assign bus.wr_ready = (state == IDLE) && !rst;
  assign bus.rd_ready = (state == IDLE) && !bus.wr_req && !rst;
  assign wr_acc       = bus.wr_req && bus.wr_ready;
  assign rd_acc       = bus.rd_req && bus.rd_ready;

  assign wr_word_idx  = word_idx(bus.wr_addr);
  assign wr_line_idx  = word_idx({bus.wr_addr[63:4], 4'h0});
  assign rd_word_idx  = word_idx(bus.rd_addr);
  assign rd_line_idx  = word_idx({bus.rd_addr[63:4], 4'h0});

  // State register and captured read request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rd_line <= 1'b0;
      rd_idx  <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rd_line <= rd_line_nxt;
      rd_idx  <= rd_idx_nxt;
    end
  end

  // Next state, latency counting and beat scheduling.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rd_line_nxt = rd_line;
    rd_idx_nxt  = rd_idx;
    emit        = 1'b0;
    emit_last   = 1'b0;
    emit_idx    = rd_idx;
    case (state)
      IDLE: begin
        if (wr_acc) begin
          state_nxt = WR_BUSY;
          cnt_nxt   = 4'(WR_LAT - 1);
        end else if (rd_acc) begin
          rd_line_nxt = (bus.rd_type == 3'd4);
          rd_idx_nxt  = (bus.rd_type == 3'd4) ? rd_line_idx : rd_word_idx;
          if (RD_LAT == 1) begin
            // Beat 0 must already be on the bus in the cycle after accept.
            emit      = 1'b1;
            emit_idx  = rd_idx_nxt;
            emit_last = !rd_line_nxt;
            state_nxt = RD_BEAT;
            cnt_nxt   = 4'd0;
          end else begin
            state_nxt = RD_WAIT;
            cnt_nxt   = 4'(RD_LAT - 1);
          end
        end
      end
      RD_WAIT: begin
        if (cnt <= 4'd1) begin
          emit      = 1'b1;
          emit_idx  = rd_idx;
          emit_last = !rd_line;
          state_nxt = RD_BEAT;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RD_BEAT: begin
        if (bus.rlast) begin
          state_nxt = IDLE;
        end else begin
          // Line refill: beat 0 is on the bus, queue the high word.
          emit      = 1'b1;
          emit_idx  = rd_idx + 1'b1;
          emit_last = 1'b1;
        end
      end
      WR_BUSY: begin
        if (cnt == 4'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered read channel; data is zero whenever no beat is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rvalid <= 1'b0;
      bus.rlast  <= 1'b0;
      bus.rdata  <= 64'd0;
    end else begin
      bus.rvalid <= emit;
      bus.rlast  <= emit && emit_last;
      bus.rdata  <= emit ? mem[emit_idx] : 64'd0;
    end
  end

  // Backing store; writes commit at the accept edge and are never reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      if (bus.wr_type == 3'd4) begin
        mem[wr_line_idx]        <= bus.wdata[63:0];
        mem[wr_line_idx + 1'b1] <= bus.wdata[127:64];
      end else begin
        for (int i = 0; i < 8; i++) begin
          if (bus.wstrb[i]) mem[wr_word_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

  logic rd_open;

  // Tracks an accepted read that has not yet delivered its rlast beat.
  always_ff @(posedge clk) begin
    if (rst)                         rd_open <= 1'b0;
    else if (rd_acc)                 rd_open <= 1'b1;
    else if (bus.rvalid && bus.rlast) rd_open <= 1'b0;
  end

  a_no_rvalid_idle: assert property (@(posedge clk) disable iff (rst)
    bus.rvalid |-> (state != IDLE && state != WR_BUSY));
  a_rlast_owned: assert property (@(posedge clk) disable iff (rst)
    (bus.rvalid && bus.rlast) |-> rd_open);
  a_single_outstanding: assert property (@(posedge clk) disable iff (rst)
    rd_acc |-> !rd_open);

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench for cache_mem_responder: directed vector table, corner sequences, random ops vs. a word-map model.
// Latency: checks exact beat timing (RD_LAT) and write busy time (WR_LAT).
// Backpressure: checks ready gating, write priority and back-to-back read acceptance.
module tb_cache_mem_responder;
  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam int          MEM_WORDS = 4096;
  localparam int          RD_LAT    = 2;
  localparam int          WR_LAT    = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  cache_mem_responder_if bus();

  cache_mem_responder #(
    .BASE_ADDR(BASE), .MEM_WORDS(MEM_WORDS), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference memory: word index -> 64-bit contents.
  logic [63:0] ref_mem [int];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int ref_idx(input logic [63:0] a);
    logic [63:0] off;
    off = a - {32'h0, BASE};
    return int'((off / 64'd8) % 64'(MEM_WORDS));
  endfunction

  task automatic model_write(input logic [63:0] a, input logic [2:0] t,
                             input logic [127:0] d, input logic [7:0] s);
    logic [63:0] base;
    logic [63:0] w;
    int          i;
    if (t == 3'd4) begin
      base = a & ~64'hF;
      ref_mem[ref_idx(base)]         = d[63:0];
      ref_mem[ref_idx(base + 64'd8)] = d[127:64];
    end else begin
      i = ref_idx(a);
      w = ref_mem.exists(i) ? ref_mem[i] : 64'd0;
      for (int b = 0; b < 8; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      ref_mem[i] = w;
    end
  endtask

  task automatic model_read(input logic [63:0] a, input logic [2:0] t,
                            output logic [63:0] e0, output logic [63:0] e1);
    logic [63:0] base;
    base = a & ~64'hF;
    e1 = 64'd0;
    if (t == 3'd4) begin
      e0 = ref_mem[ref_idx(base)];
      e1 = ref_mem[ref_idx(base + 64'd8)];
    end else begin
      e0 = ref_mem[ref_idx(a)];
    end
  endtask

  // Issue a write, wait for accept, then check the busy window.
  task automatic do_write(input logic [63:0] a, input logic [2:0] t,
                          input logic [127:0] d, input logic [7:0] s);
    int waitc = 0;
    bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_type = t; bus.wdata = d; bus.wstrb = s;
    #1;
    while (!bus.wr_ready && waitc < 20) begin @(negedge clk); #1; waitc++; end
    chk1("wr_accept_bound", bus.wr_ready, 1'b1);
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    model_write(a, t, d, s);
    for (int k = 1; k <= WR_LAT; k++) begin
      @(negedge clk);
      chk1($sformatf("wr_busy_k%0d", k), bus.wr_ready, 1'b0);
    end
    @(negedge clk);
    chk1("wr_idle_again", bus.wr_ready, 1'b1);
  endtask

  // Issue a read, wait for accept, check exact beat timing and return the data.
  task automatic do_read(input logic [63:0] a, input logic [2:0] t,
                         output logic [63:0] b0, output logic [63:0] b1);
    int waitc = 0;
    b1 = 64'd0;
    bus.rd_req = 1'b1; bus.rd_addr = a; bus.rd_type = t;
    #1;
    while (!bus.rd_ready && waitc < 20) begin @(negedge clk); #1; waitc++; end
    chk1("rd_accept_bound", bus.rd_ready, 1'b1);
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    for (int k = 1; k < RD_LAT; k++) begin
      @(negedge clk);
      chk1($sformatf("rd_wait_rvalid_k%0d", k), bus.rvalid, 1'b0);
      chk64("rd_wait_rdata_zero", bus.rdata, 64'd0);
    end
    @(negedge clk);
    chk1("rd_beat0_rvalid", bus.rvalid, 1'b1);
    chk1("rd_beat0_rlast", bus.rlast, t != 3'd4);
    b0 = bus.rdata;
    if (t == 3'd4) begin
      @(negedge clk);
      chk1("rd_beat1_rvalid", bus.rvalid, 1'b1);
      chk1("rd_beat1_rlast", bus.rlast, 1'b1);
      b1 = bus.rdata;
    end
    @(negedge clk);
    chk1("rd_after_rvalid", bus.rvalid, 1'b0);
    chk1("rd_after_rlast", bus.rlast, 1'b0);
    chk64("rd_after_rdata", bus.rdata, 64'd0);
    chk1("rd_after_ready", bus.rd_ready, 1'b1);
  endtask

  typedef struct {
    logic         is_wr;
    logic [63:0]  addr;
    logic [2:0]   typ;
    logic [127:0] wdata;
    logic [7:0]   wstrb;
    logic [63:0]  exp0;
    logic [63:0]  exp1;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [63:0]  b0, b1, e0, e1;
    logic [63:0]  a;
    logic [2:0]   t;
    logic [127:0] d;
    logic [7:0]   s;
    int           waitc;

    vecs[0]  = '{1'b1, 64'h8000_0010, 3'd4, {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 8'h00, 64'h0, 64'h0};
    vecs[1]  = '{1'b0, 64'h8000_0018, 3'd4, 128'h0, 8'h00, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
    vecs[2]  = '{1'b1, 64'h8000_0013, 3'd0, {64'h0, 64'h0000_0000_AB00_0000}, 8'h08, 64'h0, 64'h0};
    vecs[3]  = '{1'b0, 64'h8000_0010, 3'd3, 128'h0, 8'h00, 64'h1111_1111_AB11_1111, 64'h0};
    vecs[4]  = '{1'b1, 64'h8000_8000, 3'd3, {64'h0, 64'hDEAD_BEEF_0000_0001}, 8'hFF, 64'h0, 64'h0};
    vecs[5]  = '{1'b0, 64'h8000_0000, 3'd3, 128'h0, 8'h00, 64'hDEAD_BEEF_0000_0001, 64'h0};
    vecs[6]  = '{1'b0, 64'h8000_0005, 3'd0, 128'h0, 8'h00, 64'hDEAD_BEEF_0000_0001, 64'h0};
    vecs[7]  = '{1'b1, 64'h8000_0016, 3'd1, {64'h0, 64'h5566_0000_0000_0000}, 8'hC0, 64'h0, 64'h0};
    vecs[8]  = '{1'b0, 64'h8000_0010, 3'd4, 128'h0, 8'h00, 64'h5566_1111_AB11_1111, 64'h2222_2222_2222_2222};
    vecs[9]  = '{1'b0, 64'h8000_001F, 3'd7, 128'h0, 8'h00, 64'h2222_2222_2222_2222, 64'h0};
    vecs[10] = '{1'b1, 64'h8000_001C, 3'd2, {64'h0, 64'hCAFE_F00D_0000_0000}, 8'hF0, 64'h0, 64'h0};
    vecs[11] = '{1'b0, 64'h8000_0018, 3'd4, 128'h0, 8'h00, 64'h5566_1111_AB11_1111, 64'hCAFE_F00D_2222_2222};
    vecs[12] = '{1'b1, 64'h8000_8010, 3'd4, {64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B}, 8'h00, 64'h0, 64'h0};
    vecs[13] = '{1'b0, 64'h8000_0010, 3'd4, 128'h0, 8'h00, 64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};

    bus.rd_req = 1'b0; bus.rd_addr = 64'd0; bus.rd_type = 3'd0;
    bus.wr_req = 1'b0; bus.wr_addr = 64'd0; bus.wr_type = 3'd0;
    bus.wdata  = 128'd0; bus.wstrb = 8'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("reset_rvalid", bus.rvalid, 1'b0);
    chk1("reset_rlast", bus.rlast, 1'b0);
    chk64("reset_rdata", bus.rdata, 64'd0);
    chk1("reset_rd_ready", bus.rd_ready, 1'b0);
    chk1("reset_wr_ready", bus.wr_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk1("post_reset_rd_ready", bus.rd_ready, 1'b1);
    chk1("post_reset_wr_ready", bus.wr_ready, 1'b1);

    // Directed vector table
    for (int v = 0; v < 14; v++) begin
      if (vecs[v].is_wr) begin
        do_write(vecs[v].addr, vecs[v].typ, vecs[v].wdata, vecs[v].wstrb);
      end else begin
        do_read(vecs[v].addr, vecs[v].typ, b0, b1);
        chk64($sformatf("vec%0d_beat0", v), b0, vecs[v].exp0);
        if (vecs[v].typ == 3'd4) chk64($sformatf("vec%0d_beat1", v), b1, vecs[v].exp1);
      end
    end

    // Simultaneous requests: write wins, read follows WR_LAT+1 cycles later
    bus.rd_req = 1'b1; bus.rd_addr = 64'h8000_0048; bus.rd_type = 3'd4;
    bus.wr_req = 1'b1; bus.wr_addr = 64'h8000_0040; bus.wr_type = 3'd4;
    bus.wdata  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333}; bus.wstrb = 8'h00;
    #1;
    chk1("sim_wr_ready", bus.wr_ready, 1'b1);
    chk1("sim_rd_ready", bus.rd_ready, 1'b0);
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    model_write(64'h8000_0040, 3'd4, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333}, 8'h00);
    for (int k = 1; k <= WR_LAT; k++) begin
      @(negedge clk);
      chk1($sformatf("sim_rd_ready_busy_k%0d", k), bus.rd_ready, 1'b0);
    end
    @(negedge clk);
    chk1("sim_rd_ready_after", bus.rd_ready, 1'b1);
    do_read(64'h8000_0048, 3'd4, b0, b1);
    chk64("sim_beat0", b0, 64'h3333_3333_3333_3333);
    chk64("sim_beat1", b1, 64'h4444_4444_4444_4444);

    // Back-to-back line reads with rd_req held high
    bus.rd_req = 1'b1; bus.rd_addr = 64'h8000_0010; bus.rd_type = 3'd4;
    #1;
    waitc = 0;
    while (!bus.rd_ready && waitc < 20) begin @(negedge clk); #1; waitc++; end
    chk1("b2b_first_accept", bus.rd_ready, 1'b1);
    @(posedge clk); #1;
    bus.rd_addr = 64'h8000_0040;
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      @(negedge clk);
      chk1($sformatf("b2b_a_rvalid_k%0d", k), bus.rvalid, k >= RD_LAT);
      chk1($sformatf("b2b_a_rd_ready_k%0d", k), bus.rd_ready, 1'b0);
      if (k == RD_LAT) begin
        chk64("b2b_a_beat0", bus.rdata, 64'hBBBB_0000_0000_000B);
        chk1("b2b_a_rlast0", bus.rlast, 1'b0);
      end
      if (k == RD_LAT + 1) begin
        chk64("b2b_a_beat1", bus.rdata, 64'hAAAA_0000_0000_000A);
        chk1("b2b_a_rlast1", bus.rlast, 1'b1);
      end
    end
    @(negedge clk);
    chk1("b2b_second_accept_ready", bus.rd_ready, 1'b1);
    chk1("b2b_gap_rvalid", bus.rvalid, 1'b0);
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      @(negedge clk);
      chk1($sformatf("b2b_b_rvalid_k%0d", k), bus.rvalid, k >= RD_LAT);
      if (k == RD_LAT) chk64("b2b_b_beat0", bus.rdata, 64'h3333_3333_3333_3333);
      if (k == RD_LAT + 1) begin
        chk64("b2b_b_beat1", bus.rdata, 64'h4444_4444_4444_4444);
        chk1("b2b_b_rlast1", bus.rlast, 1'b1);
      end
    end
    @(negedge clk);
    chk1("b2b_b_done", bus.rvalid, 1'b0);

    // Reset asserted in the beat 0 cycle abandons the burst
    bus.rd_req = 1'b1; bus.rd_addr = 64'h8000_0040; bus.rd_type = 3'd4;
    #1;
    chk1("rstmid_accept", bus.rd_ready, 1'b1);
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    for (int k = 1; k < RD_LAT; k++) @(negedge clk);
    @(negedge clk);
    chk1("rstmid_beat0", bus.rvalid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk1("rstmid_rvalid_cleared", bus.rvalid, 1'b0);
    chk64("rstmid_rdata_cleared", bus.rdata, 64'd0);
    chk1("rstmid_rd_ready_in_rst", bus.rd_ready, 1'b0);
    chk1("rstmid_wr_ready_in_rst", bus.wr_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk1("rstmid_rd_ready_after", bus.rd_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1($sformatf("rstmid_no_beat1_k%0d", k), bus.rvalid, 1'b0);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 16; i++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      do_write(64'(BASE) + 64'(16 * i), 3'd4, d, 8'h00);
    end
    for (int n = 0; n < 80; n++) begin
      a = 64'(BASE) + 64'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) a = a + 64'(MEM_WORDS * 8);
      if ($urandom_range(0, 1) == 1) begin
        t = 3'($urandom_range(0, 4));
        s = 8'($urandom_range(0, 255));
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        do_write(a, t, d, s);
      end else begin
        t = 3'($urandom_range(0, 7));
        model_read(a, t, e0, e1);
        do_read(a, t, b0, b1);
        chk64($sformatf("rand%0d_beat0 addr=%h type=%0d", n, a, t), b0, e0);
        if (t == 3'd4) chk64($sformatf("rand%0d_beat1 addr=%h", n, a), b1, e1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
RAM-backed responder for the data cache's simple memory request interface. It serves the read side (`rd_*`, single beats and 2-beat line refills) and the write side (`wr_*`, partial-word uncached stores and 128-bit line write-backs). The block sits where the AXI bridge normally connects. It is used in the NPC sim/SoC top to close the cache miss path with fixed, configurable latency.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address mapped to memory word 0
- MEM_WORDS, 4096, depth of the 64-bit backing store (power of 2)
- RD_LAT, 2, cycles from read accept to first `rvalid` beat (legal range 1..15)
- WR_LAT, 1, busy cycles after write accept before the block returns to idle (legal range 1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_req  in  1  read request valid
- rd_addr  in  64  read byte address
- rd_type  in  3  0:1B, 1:2B, 2:4B, 3:8B, 4:cache line (16B)
- rd_ready  out  1  read request accepted this cycle when `rd_req` is also high
- rdata  out  64  read beat data
- rlast  out  1  last beat of a read
- rvalid  out  1  read beat valid (no backpressure)
- wr_req  in  1  write request valid
- wr_addr  in  64  write byte address
- wdata  in  128  write data; line uses all 128 bits, single uses [63:0], lane-aligned
- wr_type  in  3  encoding as `rd_type`
- wstrb  in  8  byte strobes for single writes, lane-aligned
- wr_ready  out  1  write request accepted this cycle when `wr_req` is also high

Behaviour:
- Word index: `((addr - BASE_ADDR) >> 3) mod MEM_WORDS`.
  - Out-of-window addresses alias (wrap-around); there is no error response.
- Line base: `addr` with bits [3:0] cleared. Beat 0 is the word at the line base; beat 1 is the word at line base + 8.
- FSM states:
  - IDLE
  - RD_WAIT: latency count
  - RD_BEAT: emits beats
  - WR_BUSY
- Handshakes:
  - `wr_ready = (state==IDLE) && !rst`.
  - `rd_ready = (state==IDLE) && !wr_req && !rst`.
  - A request is accepted on the edge where req and ready are both high; address, type, data and strobe are sampled at that edge.
  - When `rd_req` and `wr_req` are both high in IDLE, the write wins; the read stays pending. This preserves write-back-before-refill ordering.
- Write, type 4: at the accept edge, mem[base] <= `wdata[63:0]` and mem[base+8] <= `wdata[127:64]`; `wstrb` is ignored.
- Write, types 0-3: at the accept edge, the bytes of mem[index] enabled by `wstrb[i]` <= `wdata[8i+7:8i]`. No shifting is done here.
- Write timing: after accept, go to WR_BUSY for WR_LAT cycles, then IDLE.
- Read accept: go to RD_WAIT with counter = RD_LAT-1. First beat is driven in cycle T+RD_LAT, where T is the accept cycle.
- Read, type 4: two consecutive beats, low word then high word; `rlast` is high only on beat 1.
- Read, types 0-3 and 5-7: one beat carrying the full aligned 64-bit word; the requester extracts bytes by offset. `rlast` = 1 on that beat.
- After the `rlast` beat the state is IDLE in the next cycle, so `rd_ready` can be high in cycle last+1.
- Read data is fetched at beat time, so any write accepted earlier is visible. Reads and writes never overlap (single outstanding transaction).
- `rvalid`, `rlast` and `rdata` are registered. `rdata` = 0 and `rlast` = 0 whenever `rvalid` = 0.
- Reset:
  - state = IDLE; `rvalid` = 0; `rlast` = 0; `rdata` = 0; `rd_ready` = 0 and `wr_ready` = 0 while rst is high; counters = 0.
  - Memory contents are not reset.
- Reset mid-operation: an in-flight burst or write-busy is abandoned with no further beats. A write already committed at its accept edge stays committed.
- Assertions:
  - `rvalid` never high in IDLE or WR_BUSY.
  - Exactly one `rlast` per accepted read.

Test Plan:
1. Line write then line read. Write type 4 at 0x8000_0010 with wdata = {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, accepted at cycle T. Then read type 4 at 0x8000_0018, accepted at T+2 (WR_LAT=1).
   - Beat 0: `rvalid` at T+4, `rdata` = 0x1111_1111_1111_1111, `rlast` = 0.
   - Beat 1: T+5, `rdata` = 0x2222_2222_2222_2222, `rlast` = 1.
2. Byte store. Write type 0 at 0x8000_0013 with `wstrb` = 0x08 and wdata[63:0] = 0x0000_0000_AB00_0000. Then read type 3 at 0x8000_0010.
   - Single beat with `rdata` = 0x1111_1111_AB11_1111 and `rlast` = 1, RD_LAT cycles after accept.
3. Simultaneous requests. `rd_req` and `wr_req` both high in IDLE.
   - `wr_ready` = 1 and `rd_ready` = 0; the write is accepted.
   - The read is accepted WR_LAT+1 cycles later and returns the newly written data.
4. Back-to-back reads. `rd_req` held high for two type-4 reads.
   - Second accept occurs exactly 1 cycle after the first `rlast` beat.
   - No `rvalid` gap within a burst.
5. Reset mid-burst. Assert `rst` in the cycle of beat 0.
   - `rvalid` = 0 in the next cycle and beat 1 never appears.
   - `rd_ready` = 1 in the first cycle after `rst` falls.
6. Wrap-around. Write 8B of 0xDEAD_BEEF_0000_0001 at BASE_ADDR + MEM_WORDS*8.
   - A read of BASE_ADDR returns 0xDEAD_BEEF_0000_0001.
